wb_decoder_1xn: RTL

WB_DECODER_1XN -- requirements
Module: wb_decoder_1xn

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_timeout_cnt.sv | 38 +++
 rtl/wb_decoder_1xn.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone decoder definitions: classic-bus data/byte-enable widths and
// the decoder FSM state encoding.
package wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating wait counter for the decoder's REQ phase; expired_o is combinational
// and rises in the TIMEOUT-th enabled cycle after a clear (never when TIMEOUT is 0).
module wb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed waits, so the current cycle is the last allowed one at LIMIT-1
  assign expired_o = (TIMEOUT != 0) && enable_i && (cnt_q >= (LIMIT - CW'(1)));

endmodule

// File: rtl/wb_decoder_1xn.sv
// One Wishbone master to NUM_SLAVES slaves, routed by an address field; slave stb the cycle
// after the request, master ack the cycle after the slave ack; one request in flight at a time.
module wb_decoder_1xn
  import wb_pkg::*;
#(
  parameter int             NUM_SLAVES = 4,
  parameter int             SEL_LSB    = 12,
  parameter int             SEL_W      = 3,
  parameter int             SLV_AW     = 9,
  parameter int             TIMEOUT    = 255,
  parameter logic [WB_DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                         clk_i,
  input  logic                         rst,
  input  logic [WB_DW-1:0]             m_wb_dat_i,
  input  logic [31:0]                  m_wb_adr_i,
  input  logic [WB_SW-1:0]             m_wb_sel_i,
  input  logic                         m_wb_we_i,
  input  logic                         m_wb_cyc_i,
  input  logic                         m_wb_stb_i,
  output logic [WB_DW-1:0]             m_wb_dat_o,
  output logic                         m_wb_ack_o,
  output logic                         m_wb_err_o,
  input  logic [NUM_SLAVES*WB_DW-1:0]  s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]        s_wb_ack_i,
  output logic [NUM_SLAVES*WB_DW-1:0]  s_wb_dat_o,
  output logic [NUM_SLAVES*SLV_AW-1:0] s_wb_adr_o,
  output logic [NUM_SLAVES*WB_SW-1:0]  s_wb_sel_o,
  output logic [NUM_SLAVES-1:0]        s_wb_we_o,
  output logic [NUM_SLAVES-1:0]        s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]        s_wb_stb_o
);

  localparam logic [SEL_W:0] NUM_SLV = (SEL_W + 1)'(NUM_SLAVES);

  wb_state_e         state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [SLV_AW-1:0] adr_q, adr_d;
  logic [WB_DW-1:0]  wdat_q, wdat_d;
  logic [WB_SW-1:0]  sel_q, sel_d;
  logic              we_q, we_d;
  logic [WB_DW-1:0]  rdat_q, rdat_d;

  logic                  req_vld;
  logic [SEL_W-1:0]      req_idx;
  logic                  req_mapped;
  logic [NUM_SLAVES-1:0] slv_hit;
  logic [NUM_SLAVES-1:0] slv_act;
  logic                  ack_hit;
  logic [WB_DW-1:0]      ack_dat;
  logic                  tmo_clr;
  logic                  tmo_en;
  logic                  tmo_expired;
  logic                  adr_unused;

  assign req_vld    = m_wb_cyc_i & m_wb_stb_i;
  assign req_idx    = m_wb_adr_i[SEL_LSB +: SEL_W];
  assign req_mapped = ({1'b0, req_idx} < NUM_SLV);
  // address bits outside the select and word fields are don't-care
  assign adr_unused = ^m_wb_adr_i;

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_slv
    assign slv_hit[k]                     = (idx_q == SEL_W'(k));
    assign slv_act[k]                     = slv_hit[k] & (state_q == ST_REQ);
    assign s_wb_cyc_o[k]                  = slv_act[k];
    assign s_wb_stb_o[k]                  = slv_act[k];
    assign s_wb_we_o[k]                   = slv_act[k] & we_q;
    assign s_wb_dat_o[k*WB_DW +: WB_DW]   = slv_act[k] ? wdat_q : '0;
    assign s_wb_adr_o[k*SLV_AW +: SLV_AW] = slv_act[k] ? adr_q : '0;
    assign s_wb_sel_o[k*WB_SW +: WB_SW]   = slv_act[k] ? sel_q : '0;
  end

  // Only the latched target's ack and data matter; the FSM further gates by state.
  always_comb begin
    ack_hit = 1'b0;
    ack_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (slv_hit[k] && s_wb_ack_i[k]) begin
        ack_hit = 1'b1;
        ack_dat = s_wb_dat_i[k*WB_DW +: WB_DW];
      end
    end
  end

  assign tmo_en  = (state_q == ST_REQ);
  assign tmo_clr = ~tmo_en;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst       (rst),
    .clear_i   (tmo_clr),
    .enable_i  (tmo_en),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    case (state_q)
      ST_IDLE: begin
        if (req_vld) begin
          if (req_mapped) begin
            idx_d   = req_idx;
            adr_d   = m_wb_adr_i[SLV_AW+1:2];
            wdat_d  = m_wb_dat_i;
            sel_d   = m_wb_sel_i;
            we_d    = m_wb_we_i;
            state_d = ST_REQ;
          end else begin
            rdat_d  = ERR_DATA;
            state_d = ST_ERR;
          end
        end
      end
      ST_REQ: begin
        // a master abort beats a late ack; an ack beats an expiring timeout
        if (!m_wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (ack_hit) begin
          rdat_d  = ack_dat;
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          rdat_d  = ERR_DATA;
          state_d = ST_ERR;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
    end
  end

  assign m_wb_dat_o = rdat_q;
  assign m_wb_ack_o = (state_q == ST_RESP);
  assign m_wb_err_o = (state_q == ST_ERR);

endmodule
